// File: rtl/pid_loop_sequencer.sv
// One PID frame per sample period: SPI read of the ADC, PID core handshake,
// then SPI write of the result to the DAC over a shared SPI master.
module pid_loop_sequencer #(
  parameter int DATA_W   = 8,
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                ctrl_clk,
  output logic                ctrl_in_cs,
  output logic                ctrl_out_cs,
  output logic                ctrl_mosi,
  input  logic                ctrl_miso,
  output logic [DATA_W-1:0]   pv,
  output logic                calc_start,
  input  logic                calc_done,
  input  logic [DATA_W-1:0]   calc_out,
  output logic                busy,
  output logic                overrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam int             K_W    = $clog2(2 * DATA_W);
  localparam logic [K_W-1:0] K_LAST = K_W'(2 * DATA_W - 1);

  logic [2:0]          state_q,  state_d;
  logic [PERIOD_W-1:0] timer_q,  timer_d;
  logic [K_W-1:0]      k_q,      k_d;
  logic [DATA_W-1:0]   rx_q,     rx_d;
  logic [DATA_W-1:0]   tx_q,     tx_d;
  logic [DATA_W-1:0]   pv_q,     pv_d;
  logic                ovr_q,    ovr_d;
  logic                in_cs_q,  in_cs_d;
  logic                out_cs_q, out_cs_d;
  logic                sclk_q,   sclk_d;
  logic                mosi_q,   mosi_d;
  logic                start_q,  start_d;
  logic                busy_q,   busy_d;
  logic                tick_s;
  logic                frame_s;

  assign tick_s  = (timer_q == period);
  assign frame_s = (state_q == S_READ) || (state_q == S_CALC) || (state_q == S_WRITE);

  // Next-state, timer, shift registers and sticky overrun
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    k_d     = k_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    pv_d    = pv_q;
    ovr_d   = ovr_q;
    if (!en) begin
      state_d = S_IDLE;
      timer_d = {PERIOD_W{1'b0}};
      k_d     = {K_W{1'b0}};
      ovr_d   = 1'b0;
    end else begin
      if (state_q == S_IDLE) begin
        timer_d = {PERIOD_W{1'b0}};
      end else if (tick_s) begin
        timer_d = {PERIOD_W{1'b0}};
      end else begin
        timer_d = timer_q + PERIOD_W'(1);
      end
      // Ticks during a frame are dropped, only flagged
      if (tick_s && frame_s) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_q;
      end
      case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_WAIT: begin
          if (tick_s) begin
            state_d = S_READ;
            k_d     = {K_W{1'b0}};
          end else begin
            state_d = S_WAIT;
          end
        end
        S_READ: begin
          if (k_q[0]) begin
            rx_d = {rx_q[DATA_W-2:0], ctrl_miso};
          end else begin
            rx_d = rx_q;
          end
          if (k_q == K_LAST) begin
            state_d = S_CALC;
            pv_d    = {rx_q[DATA_W-2:0], ctrl_miso};
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
        S_CALC: begin
          // calc_done is ignored on the calc_start cycle
          if (!start_q && calc_done) begin
            tx_d    = calc_out;
            state_d = S_WRITE;
            k_d     = {K_W{1'b0}};
          end else begin
            state_d = S_CALC;
          end
        end
        S_WRITE: begin
          if (k_q[0]) begin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
          end else begin
            tx_d = tx_q;
          end
          if (k_q == K_LAST) begin
            state_d = S_WAIT;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output values derived from the upcoming state so that every pin is a flop
  always_comb begin
    in_cs_d  = (state_d != S_READ);
    out_cs_d = (state_d != S_WRITE);
    if ((state_d == S_READ) || (state_d == S_WRITE)) begin
      sclk_d = k_d[0];
    end else begin
      sclk_d = 1'b0;
    end
    if (state_d == S_WRITE) begin
      mosi_d = tx_d[DATA_W-1];
    end else begin
      mosi_d = 1'b0;
    end
    start_d = (state_d == S_CALC) && (state_q != S_CALC);
    busy_d  = (state_d == S_READ) || (state_d == S_CALC) || (state_d == S_WRITE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      timer_q  <= {PERIOD_W{1'b0}};
      k_q      <= {K_W{1'b0}};
      rx_q     <= {DATA_W{1'b0}};
      tx_q     <= {DATA_W{1'b0}};
      pv_q     <= {DATA_W{1'b0}};
      ovr_q    <= 1'b0;
      in_cs_q  <= 1'b1;
      out_cs_q <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      k_q      <= k_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      pv_q     <= pv_d;
      ovr_q    <= ovr_d;
      in_cs_q  <= in_cs_d;
      out_cs_q <= out_cs_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign ctrl_clk    = sclk_q;
  assign ctrl_in_cs  = in_cs_q;
  assign ctrl_out_cs = out_cs_q;
  assign ctrl_mosi   = mosi_q;
  assign pv          = pv_q;
  assign calc_start  = start_q;
  assign busy        = busy_q;
  assign overrun     = ovr_q;

endmodule

// File: doc/pid_loop_sequencer.md
Name: pid_loop_sequencer

Overview:
- Sequences one PID control-loop frame per sample period: SPI read of the process value from the sensor ADC, handshake with the PID arithmetic core, then SPI write of the result to the actuator DAC.
- Owns the shared SPI master pins (ctrl_clk, ctrl_mosi, ctrl_miso) and time-shares them between the two chip selects (ctrl_in_cs, ctrl_out_cs).
- Sits between the chip pads and the PID compute datapath inside the PID controller top level.

Parameters:
- DATA_W, 8: width of the process value and controller output; SPI transfer length in bits.
- PERIOD_W, 8: width of the sample-period register.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- en  input  1  loop enable; low aborts the current frame and holds the block idle
- period  input  PERIOD_W  sample period P; one frame tick every P+1 clk cycles
- ctrl_clk  output  1  SPI clock, mode 0, idles low
- ctrl_in_cs  output  1  sensor ADC chip select, active low
- ctrl_out_cs  output  1  actuator DAC chip select, active low
- ctrl_mosi  output  1  SPI data out, MSB first
- ctrl_miso  input  1  SPI data in from the ADC, MSB first
- pv  output  DATA_W  last captured process value
- calc_start  output  1  one-cycle pulse requesting a PID computation on pv
- calc_done  input  1  PID core result valid, sampled from the cycle after calc_start
- calc_out  input  DATA_W  PID core result, captured when calc_done=1
- busy  output  1  high in READ, CALC or WRITE
- overrun  output  1  sticky: a tick arrived while a frame was still in progress

Behaviour:
- Reset values: ctrl_clk=0, ctrl_in_cs=1, ctrl_out_cs=1, ctrl_mosi=0, pv=0, calc_start=0, busy=0, overrun=0, timer=0, state=IDLE. All outputs are registered.
- Timer: while en=1, counts 0..P and wraps to 0. A tick is generated on the cycle the timer equals P. With P=0 a tick occurs every cycle.
- States:
  - IDLE: entered on reset or en=0. Goes to WAIT on the cycle after en=1 is seen; timer starts at 0.
  - WAIT: on a tick, goes to READ on the next cycle.
  - READ: ctrl_in_cs=0 for exactly 2*DATA_W cycles, indexed k=0..2*DATA_W-1.
    - ctrl_clk = k[0].
    - ctrl_miso is shifted into a shift register at the clk edge ending each odd k, MSB first.
    - On exit, the shift register is copied to pv. Goes to CALC; ctrl_in_cs=1 on the first CALC cycle.
  - CALC: calc_start=1 on the first CALC cycle only. Waits for calc_done=1, which is sampled no earlier than the second CALC cycle. calc_out is latched into the output shift register on that edge. Goes to WRITE. No timeout.
  - WRITE: ctrl_out_cs=0 for 2*DATA_W cycles with the same k and ctrl_clk timing as READ.
    - ctrl_mosi carries latched bit DATA_W-1-(k>>1), stable across both halves of each bit.
    - Goes to WAIT; ctrl_out_cs=1 and ctrl_mosi=0 on the first WAIT cycle.
- The two chip selects are never low together. At least one cycle with both high always separates READ and WRITE.
- Latency: tick cycle t leads to ctrl_in_cs=0 at t+1. With calc_done returned at the earliest legal cycle, the minimum frame length is 4*DATA_W+2 cycles from first ctrl_in_cs low to ctrl_out_cs high.
- Overrun: a tick while state is READ, CALC or WRITE sets overrun=1 and is dropped (no queuing). The current frame completes normally. overrun clears only on reset or en=0.
- A tick on the cycle WRITE→WAIT occurs still counts as overrun. A tick on the first WAIT cycle starts a frame.
- en=0 at any time, including mid-transfer: on the next cycle the block is IDLE, both chip selects are 1, ctrl_clk=0, ctrl_mosi=0, calc_start=0, timer and overrun are cleared. pv holds its value. A partial read does not update pv.
- Reset asserted mid-operation: immediately forces all reset values.
- pv is updated only at the end of a complete READ.

Test Plan:
- Reset: reset=0 with random inputs → all outputs at reset values, ctrl_in_cs=ctrl_out_cs=1; release with en=0 → no SPI activity for 100 cycles.
- Nominal frame (DATA_W=8, P=63): en=1, ADC model drives 0xA5, PID model returns calc_done 3 cycles after calc_start with calc_out=0x3C → ctrl_in_cs low exactly 16 cycles, pv=0xA5, a single 1-cycle calc_start, ctrl_out_cs low 16 cycles, DAC model receives 0x3C. Frames repeat every 64 cycles with overrun=0.
- Overrun: P=20 (below the 34-cycle frame) → overrun=1 after the first frame. Frames still complete whole, never overlap, and the chip selects are never low together.
- Abort: en=0 at READ k=7 → next cycle IDLE, both chip selects high, ctrl_clk=0, pv keeps its old value; en=1 → the next frame reads correctly.
- Slow compute: calc_done held low for 200 cycles with P=63 → block stays in CALC, busy=1, overrun=1; on calc_done=1 the WRITE proceeds with the latched calc_out.
- Boundary: P=0 → overrun set during the first frame; ADC pattern 0x00 then 0xFF → pv matches exactly, MSB-first ordering confirmed.
